// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Contents: op encodings (MIPS mult/multu/div/divu), FSM state encoding,
// and the LO value returned on a divide by zero.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the mul/div unit.
// master: drives start/op/a/b and the mthi/mtlo writes, observes status and HI/LO.
// slave : the mul/div unit itself.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    import muldiv_pkg::*;

    logic             start;
    md_op_e           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu with architectural HI/LO and mthi/mtlo.
// Latency: WIDTH+1 edges after the launch edge (WIDTH CALC iterations + one FIX edge).
// Backpressure: busy stalls the PC; start and hi/lo writes are ignored unless IDLE.
// Ports: clk, reset (async active-high), md (muldiv_if.slave).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  md
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_e             op_q, op_d;
    // Shared accumulator: mult = {partial product, multiplier}, div = {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand magnitude for mult, divisor magnitude for div
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    // One shift-add multiply step: add multiplicand when the multiplier LSB is set, shift right
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    // One restoring divide step: trial-subtract the divisor from the remainder shifted left by one
    logic [WIDTH:0]     div_trial;
    logic               div_borrow;
    logic [2*WIDTH-1:0] div_next;

    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_trial  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign div_borrow = div_trial[WIDTH];
    assign div_next   = {(div_borrow ? acc_q[2*WIDTH-2:WIDTH-1] : div_trial[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], ~div_borrow};

    logic             is_signed;
    logic             is_div;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [2*WIDTH-1:0] prod_fix;

    assign is_signed = (md.op == MD_MULT) || (md.op == MD_DIV);
    assign is_div    = md.op[1];
    assign a_mag     = cond_neg(md.a, is_signed & md.a[WIDTH-1]);
    assign b_mag     = cond_neg(md.b, is_signed & md.b[WIDTH-1]);
    assign prod_fix  = qneg_q ? -acc_q : acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (md.hi_we) hi_d = md.a;
                if (md.lo_we) lo_d = md.a;
                if (md.start) begin
                    op_d   = md.op;
                    qneg_d = is_signed & (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
                    rneg_d = is_signed & md.a[WIDTH-1];
                    dz_d   = is_div && (md.b == '0);
                    acc_d  = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                    opnd_d = is_div ? b_mag : a_mag;
                    cnt_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (op_q[1]) begin
                    // With a zero divisor every trial succeeds, so the remainder ends up
                    // as |a|; the dividend-sign fix-up then restores the original a.
                    lo_d = dz_q ? DIV0_LO : cond_neg(acc_q[WIDTH-1:0], qneg_q);
                    hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], rneg_q);
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                dbz_d   = dz_q;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            acc_q   <= '0;
            opnd_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign md.busy        = (state_q != IDLE);
    assign md.done        = done_q;
    assign md.div_by_zero = dbz_q;
    assign md.hi          = hi_q;
    assign md.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: transaction-level model plus per-cycle output compare,
// with directed vectors and hand-computed literal results.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    muldiv_if #(.WIDTH(W)) md ();

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the instruction definitions
    task automatic compute(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rh, output logic [31:0] rl, output bit dz);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] up;
        dz = 1'b0;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            MD_MULT:  begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
            MD_MULTU: begin up = {32'b0, a} * {32'b0, b}; rh = up[63:32]; rl = up[31:0]; end
            MD_DIV: begin
                if (b == 32'd0) begin rh = a; rl = 32'hFFFF_FFFF; dz = 1'b1; end
                else begin sq = sa / sb; sr = sa % sb; rl = sq[31:0]; rh = sr[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin rh = a; rl = 32'hFFFF_FFFF; dz = 1'b1; end
                else begin rl = a / b; rh = a % b; end
            end
        endcase
    endtask

    // Model state
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    bit          m_done = 0, m_dz = 0, r_dz = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_done = 0; m_dz = 0;
        end else begin
            m_done = 0;
            m_dz   = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = r_hi; m_lo = r_lo; m_done = 1; m_dz = r_dz;
                end
            end else begin
                if (md.hi_we) m_hi = md.a;
                if (md.lo_we) m_lo = md.a;
                if (md.start) begin
                    compute(md.op, md.a, md.b, r_hi, r_lo, r_dz);
                    m_left = W + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'b0, md.busy}, {31'b0, (m_left > 0)});
        chk("done", {31'b0, md.done}, {31'b0, m_done});
        chk("div_by_zero", {31'b0, md.div_by_zero}, {31'b0, m_dz});
        chk("hi", md.hi, m_hi);
        chk("lo", md.lo, m_lo);
    end

    task automatic launch(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        md.start = 1'b1; md.op = op; md.a = a; md.b = b;
        @(posedge clk); #1;
        md.start = 1'b0;
        md.op = md_op_e'($urandom_range(3));
        md.a = $urandom;
        md.b = $urandom;
    endtask

    // Returns at the negedge where done is seen; counts busy cycles before it
    task automatic wait_done(output int bc);
        bit seen = 0;
        bc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (md.done) begin seen = 1; break; end
            if (md.busy) bc++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_done: no done within 100 cycles at %0t", $time);
        end
    endtask

    task automatic run(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input string name, input logic [31:0] eh, input logic [31:0] el,
                       input bit edz);
        int bc;
        launch(op, a, b);
        wait_done(bc);
        chk({name, "_hi"}, md.hi, eh);
        chk({name, "_lo"}, md.lo, el);
        chk({name, "_dz"}, {31'b0, md.div_by_zero}, {31'b0, edz});
    endtask

    initial begin
        int bc;
        md.start = 1'b0; md.op = MD_MULT; md.a = '0; md.b = '0;
        md.hi_we = 1'b0; md.lo_we = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, md.busy}, 32'd0);
        chk("rst_hi", md.hi, 32'd0);
        chk("rst_lo", md.lo, 32'd0);

        // signed mult -3*5, with busy width
        launch(MD_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(bc);
        chk("mult_busy_cycles", bc, 32'd33);
        chk("mult_hi", md.hi, 32'hFFFF_FFFF);
        chk("mult_lo", md.lo, 32'hFFFF_FFF1);

        run(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu", 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run(MD_DIV,   32'hFFFF_FFF9, 32'd2,        "div",   32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run(MD_DIVU,  32'd100,       32'd7,        "divu",  32'd2,         32'd14,        0);
        run(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32'd0,      32'h8000_0000, 0);
        run(MD_DIV,   32'hFFFF_FFF9, 32'd0,        "div0s", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
        run(MD_DIVU,  32'h1234,      32'd0,        "div0",  32'h1234,      32'hFFFF_FFFF, 1);
        run(MD_MULT,  32'd3,         32'd4,        "mult_after_dz", 32'd0, 32'd12,        0);

        // start and mthi during busy are ignored
        launch(MD_MULT, 32'd6, 32'd7);
        repeat (8) @(posedge clk);
        #1 md.start = 1'b1; md.op = MD_DIVU; md.hi_we = 1'b1; md.a = 32'h5555_5555; md.b = 32'd3;
        @(posedge clk); #1 md.start = 1'b0; md.hi_we = 1'b0;
        wait_done(bc);
        chk("ign_hi", md.hi, 32'd0);
        chk("ign_lo", md.lo, 32'd42);
        @(negedge clk);
        chk("ign_no_relaunch", {31'b0, md.busy}, 32'd0);

        // mtlo in IDLE
        @(posedge clk); #1 md.lo_we = 1'b1; md.a = 32'hABCD;
        @(posedge clk); #1 md.lo_we = 1'b0;
        chk("mtlo", md.lo, 32'hABCD);

        // mthi + start in same cycle: write lands, result overwrites later
        @(posedge clk); #1 md.hi_we = 1'b1; md.start = 1'b1; md.op = MD_MULTU; md.a = 32'd9; md.b = 32'd9;
        @(posedge clk); #1 md.hi_we = 1'b0; md.start = 1'b0;
        chk("mthi_with_start", md.hi, 32'd9);
        wait_done(bc);
        chk("mthi_then_result_lo", md.lo, 32'd81);
        chk("mthi_then_result_hi", md.hi, 32'd0);

        // async reset mid-divide
        launch(MD_DIV, 32'd1000, 32'd3);
        repeat (13) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, md.busy}, 32'd0);
        chk("midrst_done", {31'b0, md.done}, 32'd0);
        chk("midrst_dz", {31'b0, md.div_by_zero}, 32'd0);
        chk("midrst_hi", md.hi, 32'd0);
        chk("midrst_lo", md.lo, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        launch(MD_MULT, 32'd2, 32'd3);
        wait_done(bc);
        chk("post_rst_busy_cycles", bc, 32'd33);
        chk("post_rst_lo", md.lo, 32'd6);
        chk("post_rst_hi", md.hi, 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. It sits in the execute stage beside the ALU and is fed from the same rs/rt operand muxes.
- It replaces the ALU's combinational mult/div paths, which are kept only as legacy encodings.
- The control unit stalls the PC while busy=1. The hi/lo outputs feed the writeback mux for mfhi/mflo.
- Implements MIPS32 mult, multu, div and divu, plus mthi/mtlo.

Parameters:
- WIDTH, 32, operand width; hi, lo, a and b are all WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- hi_we  input  1  mthi: hi <= a
- lo_we  input  1  mtlo: lo <= a
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when hi/lo are updated by an operation
- div_by_zero  output  1  one-cycle pulse coincident with done; set for div/divu with b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, div_by_zero=0; hi=0, lo=0; counter=0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, CALC, FIX.
  - IDLE -> CALC on start=1.
  - CALC -> FIX when counter reaches WIDTH-1, i.e. after WIDTH iterations.
  - FIX -> IDLE unconditionally.
- Launch (start=1 in IDLE at edge N):
  - Latch op.
  - Latch operand magnitudes: |a| and |b| for signed ops, raw values for unsigned ops.
  - Latch result sign flags:
    - product/quotient sign = a[31]^b[31];
    - remainder sign = a[31].
  - busy=1 from edge N through edge N+WIDTH+1 inclusive.
- Timing:
  - CALC performs one iteration per cycle, on edges N+1 .. N+WIDTH.
  - FIX executes at edge N+WIDTH+1:
    - applies two's-complement sign correction;
    - writes hi/lo;
    - sets done=1 and busy=0.
  - done deasserts at the next edge.
  - Total latency is WIDTH+1 edges after the launch edge (33 for WIDTH=32).
- Multiply:
  - Shift-add over a 2*WIDTH accumulator.
  - Result is {hi,lo} = full 2*WIDTH product, negated in FIX if the product sign is set (signed op only).
- Divide:
  - Restoring division: shift the remainder left, trial-subtract the divisor, shift the quotient bit into lo.
  - lo = quotient, hi = remainder.
  - Signed: the quotient is negated if its sign flag is set; the remainder takes the dividend's sign.
  - Edge case: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero:
  - Runs the full latency.
  - Result: hi=a (original), lo=0xFFFFFFFF.
  - div_by_zero=1 together with done.
- start while busy: ignored; no queueing.
  - start in the same cycle as the FIX edge is also ignored; it is accepted only from IDLE.
- hi_we/lo_we:
  - Honoured only in IDLE; ignored while busy.
  - If hi_we/lo_we and start are asserted in the same IDLE cycle, the write occurs and the operation launches. The operation's later FIX result overwrites both registers.
- hi/lo hold their values between operations; only FIX, hi_we/lo_we and reset change them.
- op and a/b may change freely after the launch edge; the internal copies are used.

Decomposition:
- Shared package (muldiv_pkg):
  - op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - state encoding IDLE/CALC/FIX;
  - DIV0_LO constant 32'hFFFFFFFF.
- No sub-module is required. The FSM, counter and shared accumulator datapath live in one module.
- The sign fix-up negation may be a local function rather than a separate module.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=5 -> after 33 edges: done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu a=100, b=7 -> lo=14, hi=2.
- divu a=0x1234, b=0 -> done and div_by_zero pulse together; hi=0x1234, lo=0xFFFFFFFF. A following mult clears div_by_zero to 0 at its done.
- Launch mult 6*7, pulse start with op=divu and hi_we=1 at cycle 10 -> both ignored; result hi=0, lo=42. Then mtlo a=0xABCD in IDLE -> lo=0xABCD next edge.
- Launch div, assert reset at cycle 15 -> busy, done and div_by_zero are immediately 0, hi=lo=0; a fresh mult 2*3 afterwards returns lo=6 with full latency.
